// File: rtl/prog_loader.sv
// prog_loader: byte-serial program loader in front of the MIPS core.
// Parses a framed byte stream (A5, length hi/lo, 4*N data bytes, XOR checksum),
// writes big-endian instruction words to word addresses 0..N-1, and holds the
// core in reset until the whole frame has been loaded and its checksum matched.
//
// Handshake: a byte moves from the source into the loader on a rising edge where
// byte_valid && byte_ready are both high. The source keeps byte_data stable while
// byte_valid is high and unaccepted; byte_ready is a registered output that is high
// exactly while the loader is in a byte-consuming state.
module prog_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HDR    = 3'd1,
      S_LEN_HI = 3'd2,
      S_LEN_LO = 3'd3,
      S_DATA   = 3'd4,
      S_CSUM   = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam logic [7:0]  HDR_BYTE = 8'hA5;
   localparam logic [16:0] MAX_LEN  = 17'(MAX_WORDS);

   state_t      state;
   logic [15:0] len;        // program length N in words
   logic [23:0] word_sr;    // first three bytes of the word being assembled
   logic [1:0]  byte_cnt;   // position of the next data byte inside its word
   logic [7:0]  csum;       // running XOR of data bytes

   logic        xfer;
   logic [15:0] len_next;
   logic        len_bad;
   logic [15:0] words_next;

   assign xfer       = byte_valid && byte_ready;
   assign len_next   = {len[15:8], byte_data};
   assign len_bad    = (len_next == 16'd0) || ({1'b0, len_next} > MAX_LEN);
   assign words_next = 16'(word_count) + 16'd1;
   assign state_dbg  = state;

   // Frame-parsing FSM; every output is registered and updated on the transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= 2'd0;
         word_count <= '0;
         len        <= '0;
         word_sr    <= '0;
         byte_cnt   <= 2'd0;
         csum       <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (state == S_IDLE) begin
                  word_count <= '0;
                  csum       <= '0;
                  byte_cnt   <= 2'd0;
               end
               if (start) begin
                  state      <= S_HDR;
                  byte_ready <= 1'b1;
                  cpu_rst    <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  err_code   <= 2'd0;
                  word_count <= '0;
                  csum       <= '0;
                  byte_cnt   <= 2'd0;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  if (byte_data == HDR_BYTE) begin
                     state <= S_LEN_HI;
                  end else begin
                     state      <= S_ERR;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                     err_code   <= 2'd1;
                  end
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  len[15:8] <= byte_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  len <= len_next;
                  if (len_bad) begin
                     state      <= S_ERR;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                     err_code   <= 2'd2;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  word_sr  <= {word_sr[15:0], byte_data};
                  csum     <= csum ^ byte_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_count[ADDR_WIDTH-1:0];
                     imem_wdata <= {word_sr, byte_data};
                     word_count <= word_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
                     // byte_ready stays high so the checksum can follow immediately
                     if (words_next == len) state <= S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  byte_ready <= 1'b0;
                  if (byte_data == csum) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     cpu_rst <= 1'b0;
                  end else begin
                     state    <= S_ERR;
                     error    <= 1'b1;
                     err_code <= 2'd3;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model plus
// per-cycle output comparison and a few hand-computed pinned results.
module tb_prog_loader;
  localparam int ADDR_WIDTH = 10;
  localparam int MAX_WORDS  = 1024;
  localparam int EW         = ADDR_WIDTH + 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = 8'h00;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  cpu_rst;
  logic                  done;
  logic                  error;
  logic [1:0]            err_code;
  logic [ADDR_WIDTH:0]   word_count;
  logic [2:0]            state_dbg;

  prog_loader #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error), .err_code(err_code),
    .word_count(word_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  logic [7:0]    frame_q[$];   // frame the stimulus is about to send
  logic [EW-1:0] exp_q[$];     // expected {addr, data} writes of the running frame
  logic [EW-1:0] wr_log[$];    // every write seen since the current frame began

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Frame-level reference: how many bytes the loader must take, the length
  // field, and the outcome code; optionally queues the expected writes.
  function automatic void parse_frame(input logic [7:0] f[$], input bit push,
                                      output int need, output int n, output int code);
    logic [7:0]  x;
    logic [31:0] w;
    n = 0;
    if (f[0] != 8'hA5) begin need = 1; code = 1; return; end
    n = int'({f[1], f[2]});
    if (n == 0 || n > MAX_WORDS) begin need = 3; code = 2; return; end
    need = 4 * n + 4;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {f[3+4*i], f[4+4*i], f[5+4*i], f[6+4*i]};
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      if (push) exp_q.push_back({ADDR_WIDTH'(i), w});
    end
    code = (f[4*n+3] == x) ? 0 : 3;
  endfunction

  // ---------------- model state ----------------
  logic m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, we_pend = 1'b0;
  int   m_need = 0, m_consumed = 0, m_n = 0, m_code = 0, m_wc = 0;

  // Compare outputs of the current cycle, then advance the model by the
  // inputs that the next rising edge will sample.
  always @(negedge clk) begin : cmp
    int k;
    if (chk_en) begin
      chk("imem_we", imem_we, we_pend);
      if (imem_we) begin
        wr_log.push_back({imem_addr, imem_wdata});
        if (exp_q.size() == 0) chk("unexpected_write", imem_we, 1'b0);
        else chk("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
      chk("byte_ready", byte_ready, m_active && (m_consumed < m_need));
      chk("done", done, m_done);
      chk("cpu_rst", cpu_rst, !m_done);
      chk("error", error, m_err);
      chk("err_code", err_code, m_err ? m_code : 0);
      chk("word_count", word_count, m_wc);
    end
    we_pend = 1'b0;
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0; m_wc = 0; m_consumed = 0; m_need = 0;
      exp_q.delete();
    end else if (!m_active && start) begin
      exp_q.delete();
      parse_frame(frame_q, 1'b1, m_need, m_n, m_code);
      m_active = 1; m_done = 0; m_err = 0; m_wc = 0; m_consumed = 0;
    end else if (m_active && byte_valid && m_consumed < m_need) begin
      k = m_consumed;
      m_consumed++;
      if ((m_code == 0 || m_code == 3) && k >= 6 && k <= 4 * m_n + 2 && (k - 6) % 4 == 0) begin
        we_pend = 1'b1;
        m_wc++;
      end
      if (m_consumed == m_need) begin
        m_active = 0;
        m_done   = (m_code == 0);
        m_err    = (m_code != 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit stray);
    int waited;
    while ($urandom_range(0, 99) < gap_pct) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      start      = stray && ($urandom_range(0, 3) == 0);
      step();
    end
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    while (!byte_ready && waited < 64) begin step(); waited++; end
    if (!byte_ready) chk("handshake_timeout", byte_ready, 1'b1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap_pct, input bit stray);
    int need, n, code;
    parse_frame(frame_q, 1'b0, need, n, code);
    wr_log.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < need; i++) send_byte(frame_q[i], gap_pct, stray);
    // offer bytes the loader must not take
    byte_valid = 1'b1;
    repeat (3) begin byte_data = 8'($urandom); step(); end
    byte_valid = 1'b0;
    step();
  endtask

  task automatic make_frame(input int n, input bit bad);
    logic [7:0]  x, b;
    logic [15:0] n16;
    n16 = 16'(n);
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n16[15:8]);
    frame_q.push_back(n16[7:0]);
    x = 8'h00;
    repeat (4 * n) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x = x ^ b;
    end
    frame_q.push_back(bad ? ~x : x);
  endtask

  task automatic normal_frame(input logic [7:0] cs);
    // 20010005 ^ 2002000A bytewise XOR = 0x0C
    frame_q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                8'h20, 8'h02, 8'h00, 8'h0A, cs};
  endtask

  task automatic pin_normal_writes(input string tag);
    logic [EW-1:0] e;
    chk({tag, "_nwrites"}, wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      e = wr_log[0]; chk({tag, "_w0"}, e, {10'd0, 32'h20010005});
      e = wr_log[1]; chk({tag, "_w1"}, e, {10'd1, 32'h2002000A});
    end
  endtask

  task automatic pin_reset_values();
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_imem_we", imem_we, 1'b0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_err_code", err_code, 0);
    chk("rst_word_count", word_count, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [EW-1:0] e;
    rst = 1'b1;
    step();
    step();
    pin_reset_values();
    rst = 1'b0;
    chk_en = 1'b1;

    // normal load, no gaps
    normal_frame(8'h0C);
    run_frame(0, 1'b0);
    pin_normal_writes("normal");
    chk("normal_word_count", word_count, 2);
    chk("normal_done", done, 1'b1);
    chk("normal_cpu_rst", cpu_rst, 1'b0);

    // same frame under back-pressure, with start pulses during the load
    normal_frame(8'h0C);
    run_frame(40, 1'b1);
    pin_normal_writes("bp");
    chk("bp_done", done, 1'b1);

    // bad header
    frame_q = '{8'h5A, 8'h00, 8'h02, 8'h00};
    run_frame(0, 1'b0);
    chk("badhdr_error", error, 1'b1);
    chk("badhdr_code", err_code, 2'd1);
    chk("badhdr_cpu_rst", cpu_rst, 1'b1);
    chk("badhdr_nwrites", wr_log.size(), 0);

    // length 0 and length MAX_WORDS+1
    make_frame(0, 1'b0);
    run_frame(20, 1'b0);
    chk("len0_code", err_code, 2'd2);
    chk("len0_nwrites", wr_log.size(), 0);
    make_frame(MAX_WORDS + 1, 1'b0);
    run_frame(20, 1'b0);
    chk("lenmax1_code", err_code, 2'd2);
    chk("lenmax1_nwrites", wr_log.size(), 0);

    // checksum mismatch, then a good frame
    normal_frame(8'h30);
    run_frame(0, 1'b0);
    pin_normal_writes("badcs");
    chk("badcs_code", err_code, 2'd3);
    chk("badcs_cpu_rst", cpu_rst, 1'b1);
    normal_frame(8'h0C);
    run_frame(10, 1'b0);
    chk("after_badcs_done", done, 1'b1);

    // largest program
    make_frame(MAX_WORDS, 1'b0);
    run_frame(0, 1'b0);
    chk("max_nwrites", wr_log.size(), MAX_WORDS);
    if (wr_log.size() > 0) begin
      e = wr_log[wr_log.size() - 1];
      chk("max_last_addr", e[EW-1:32], MAX_WORDS - 1);
    end
    chk("max_done", done, 1'b1);

    // reset after six data bytes, with start in the same cycle as rst
    normal_frame(8'h0C);
    wr_log.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(frame_q[i], 0, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    pin_reset_values();
    chk("midrst_nwrites", wr_log.size(), 1);
    if (wr_log.size() >= 1) begin
      e = wr_log[0];
      chk("midrst_w0", e, {10'd0, 32'h20010005});
    end
    step();
    normal_frame(8'h0C);
    run_frame(15, 1'b0);
    pin_normal_writes("reload");
    chk("reload_done", done, 1'b1);

    // randomized frames
    for (int t = 0; t < 12; t++) begin
      make_frame($urandom_range(1, 6), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 5) == 0) frame_q[0] = 8'($urandom_range(0, 164));
      run_frame($urandom_range(0, 50), 1'b1);
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
